// File: rtl/sha256_msched.sv
// rtl/sha256_msched.sv - Iterative SHA-256 message-schedule engine (optional abort port: SHA256_MSCHED_ABORT_EN)
module sha256_msched (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last
`ifdef SHA256_MSCHED_ABORT_EN
    ,
    input  logic        abort
`endif
);

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Sliding window: win[0] is W[t], win[15] is W[t+15]
    logic [31:0] win [16];
    logic [3:0]  lcnt;
    logic [5:0]  t;

    logic        kill;
    logic        in_hs;
    logic        out_hs;
    logic [31:0] next_word;

`ifdef SHA256_MSCHED_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction

    // Handshakes are qualified by the registered state only, so no output
    // depends combinationally on in_valid or out_ready.
    assign in_hs     = (state == LOAD) && in_valid;
    assign out_hs    = (state == EXPAND) && out_ready;

    // Expansion word appended at the top of the window on every shift; words
    // past W63 are still computed but never reach out_word.
    assign next_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    assign out_word  = win[0];
    assign out_idx   = t;

    // State register
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_hs && (lcnt == 4'd15)) begin
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                out_valid = 1'b1;
                out_last  = (t == 6'd63);
                if (out_hs && (t == 6'd63)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
        if (kill) begin
            state_nxt = LOAD;
        end
    end

    // Window, load counter and output index
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lcnt <= 4'd0;
            t    <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else if (kill) begin
            // Abandon the block; stale window contents are overwritten by the next load
            lcnt <= 4'd0;
            t    <= 6'd0;
        end else begin
            if (in_hs) begin
                win[lcnt] <= in_word;
                lcnt      <= lcnt + 4'd1;
                if (lcnt == 4'd15) begin
                    t <= 6'd0;
                end
            end
            if (out_hs) begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i + 1];
                end
                win[15] <= next_word;
                t       <= (t == 6'd63) ? 6'd0 : t + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msched.sv
// tb/tb_sha256_msched.sv - Self-checking bench for sha256_msched against a schedule reference model
module tb_sha256_msched;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;
`ifdef SHA256_MSCHED_ABORT_EN
    logic        abort = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_load;
    int          cyc_drain;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    sha256_msched dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef SHA256_MSCHED_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic set_zero_block();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    endtask

    task automatic set_abc_block();
        set_zero_block();
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic load_block(input bit gaps, output int cycles);
        int k = 0;
        int cyc = 0;
        while (k < 16 && cyc < 300) begin
            check("load_in_ready", {31'd0, in_ready}, 32'd1);
            check("load_out_valid", {31'd0, out_valid}, 32'd0);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_word  = in_valid ? blk[k] : $urandom;
            step();
            if (in_valid) k++;
            cyc++;
        end
        in_valid = 1'b0;
        cycles = cyc;
        check("load_count", k, 16);
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        check("first_idx", {26'd0, out_idx}, 32'd0);
    endtask

    task automatic drain(input int n_words, input bit stall, input bit poke_in, output int cycles);
        int idx = 0;
        int cyc = 0;
        logic [31:0] prev = 32'd0;
        bit prev_stall = 1'b0;
        while (idx < n_words && cyc < 2000) begin
            check("exp_out_valid", {31'd0, out_valid}, 32'd1);
            check("exp_in_ready", {31'd0, in_ready}, 32'd0);
            check("out_idx", {26'd0, out_idx}, idx);
            check($sformatf("out_word[%0d]", idx), out_word, exp_w[idx]);
            check("out_last", {31'd0, out_last}, {31'd0, idx == 63});
            if (prev_stall) check("stall_stable", out_word, prev);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_in) begin
                in_valid = 1'b1;
                in_word  = $urandom;
            end
            prev       = out_word;
            prev_stall = !out_ready;
            got_w[idx] = out_word;
            step();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        cycles = cyc;
        check("drain_count", idx, n_words);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_out_idx"}, {26'd0, out_idx}, 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        g_reset = 1'b0;
        check_idle("reset");
        check("reset_out_word", out_word, 32'd0);

        // "abc" block with full throughput
        set_abc_block();
        build_model();
        load_block(1'b0, cyc_load);
        check("abc_load_cycles", cyc_load, 16);
        drain(64, 1'b0, 1'b0, cyc_drain);
        check("abc_drain_cycles", cyc_drain, 64);
        check("abc_W16", got_w[16], 32'h61626380);
        check("abc_W17", got_w[17], 32'h000F0000);
        check_idle("abc_end");

        // sigma0 probe
        set_zero_block();
        blk[1] = 32'h00000001;
        build_model();
        load_block(1'b0, cyc_load);
        drain(64, 1'b0, 1'b0, cyc_drain);
        check("s0_W16", got_w[16], 32'h02004000);

        // sigma1 probe
        set_zero_block();
        blk[14] = 32'h00000001;
        build_model();
        load_block(1'b0, cyc_load);
        drain(64, 1'b0, 1'b0, cyc_drain);
        check("s1_W16", got_w[16], 32'h0000A000);

        // All-zero block with random stalls and in_valid held during expansion
        set_zero_block();
        build_model();
        load_block(1'b0, cyc_load);
        drain(64, 1'b1, 1'b1, cyc_drain);
        check_idle("zero_end");

        // Random blocks with input gaps, stalls and input poking
        for (int b = 0; b < 3; b++) begin
            set_rand_block();
            build_model();
            load_block(1'b1, cyc_load);
            drain(64, 1'b1, 1'b1, cyc_drain);
            check_idle("rand_end");
        end

        // Reset mid-expansion, then a clean "abc" block
        set_rand_block();
        build_model();
        load_block(1'b0, cyc_load);
        drain(30, 1'b0, 1'b0, cyc_drain);
        g_reset   = 1'b1;
        out_ready = 1'b1;
        step();
        g_reset   = 1'b0;
        out_ready = 1'b0;
        check_idle("midreset");
        check("midreset_out_word", out_word, 32'd0);
        set_abc_block();
        build_model();
        load_block(1'b0, cyc_load);
        drain(64, 1'b0, 1'b0, cyc_drain);
        check("post_reset_W16", got_w[16], 32'h61626380);
        check("post_reset_W17", got_w[17], 32'h000F0000);

        // Reset mid-load
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_word  = $urandom;
            step();
        end
        g_reset = 1'b1;
        step();
        g_reset  = 1'b0;
        in_valid = 1'b0;
        check_idle("loadreset");
        set_rand_block();
        build_model();
        load_block(1'b1, cyc_load);
        drain(64, 1'b0, 1'b0, cyc_drain);

`ifdef SHA256_MSCHED_ABORT_EN
        // Abort after 7 loaded words, with an input handshake in the abort cycle
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_word  = $urandom;
            step();
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        in_word  = $urandom;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_load");
        set_rand_block();
        build_model();
        load_block(1'b0, cyc_load);
        drain(64, 1'b0, 1'b0, cyc_drain);

        // Abort coinciding with an output handshake
        set_rand_block();
        build_model();
        load_block(1'b0, cyc_load);
        drain(5, 1'b0, 1'b0, cyc_drain);
        abort     = 1'b1;
        out_ready = 1'b1;
        step();
        abort     = 1'b0;
        out_ready = 1'b0;
        check_idle("abort_exp");
        set_rand_block();
        build_model();
        load_block(1'b1, cyc_load);
        drain(64, 1'b1, 1'b0, cyc_drain);
        check_idle("abort_exp_end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msched.md
# sha256_msched

Iterative SHA-256 message-schedule engine. It accepts one 512-bit message block as 16 big-endian 32-bit words and streams out the 64 schedule words W0..W63 in order, one per handshake. It computes the expansion with the small-sigma functions σ0 and σ1, the same transforms exposed by the lightweight SHA-256 instructions. It sits between a block buffer and a compression-round datapath, and serves as the hardware reference and driver-side counterpart of those instruction functions.

## Interface
- No parameters.
- g_clk  in  1  clock; all state updates on rising edge.
- g_reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_word valid.
- in_ready  out  1  engine accepts a block word this cycle.
- in_word  in  32  block word, W0 first.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts out_word.
- out_word  out  32  schedule word W[out_idx].
- out_idx  out  6  index t of out_word, 0..63.
- out_last  out  1  high with out_valid when out_idx==63.
- abort  in  1  present only with SHA256_MSCHED_ABORT_EN; discard current block.

## Operation
- Storage: 16×32 window win[0..15] holding W[t..t+15]; 4-bit load counter lcnt; 6-bit output counter t.
- States: LOAD and EXPAND.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: win[lcnt]←in_word, lcnt++.
  - On the 16th accept (lcnt==15): go to EXPAND, t←0, lcnt←0.
- EXPAND:
  - in_ready=0, out_valid=1, out_word=win[0], out_idx=t, out_last=(t==63).
  - On out_valid&out_ready: shift win left one place; win[15]←σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
  - σ0(x)=ror(x,7)^ror(x,18)^(x>>3); σ1(x)=ror(x,17)^ror(x,19)^(x>>10).
  - New words are computed on every shift, including t≥48; values beyond W63 are never emitted.
  - On handshake with t==63: go to LOAD.
  - Otherwise t++.
- No handshake in EXPAND: window and t hold, out_word stable.
- in_valid while in EXPAND is ignored; nothing is consumed.

## Timing
- Reset values: state=LOAD, lcnt=0, t=0, in_ready=1, out_valid=0, out_last=0, out_idx=0. win is cleared to 0, so out_word=0.
- Latency: out_valid rises the cycle after the 16th input handshake, with W0.
- Throughput:
  - 1 word/cycle in both phases.
  - A block takes 16+64=80 cycles with no stalls.
  - in_ready returns to 1 the cycle after the W63 handshake.
- Outputs are registered (win[0], t, state). They do not depend combinationally on out_ready or in_valid.
- g_reset takes precedence over every other input. Reset mid-LOAD or mid-EXPAND discards the block and returns to the reset values next cycle.
- Gaps in in_valid during LOAD are allowed; lcnt holds.

## Configuration
- SHA256_MSCHED_ABORT_EN defined:
  - abort port exists.
  - abort=1 on a rising edge forces state=LOAD, lcnt=0, t=0 next cycle, in either state.
  - Any handshake in that cycle is discarded.
  - Priority is g_reset > abort > handshake.
- Undefined: no abort port; a block can only be cleared by g_reset.

## Test plan
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> 64 words, W16=0x61626380, W17=0x000F0000, out_last only at out_idx=63, next in_ready one cycle later.
- Block W1=0x00000001, all others 0 -> W16=0x02004000 (σ0 check); block W14=0x00000001, all others 0 -> W16=0x0000A000 (σ1 check).
- All-zero block with random out_ready stalls -> 64 zero words, out_idx strictly increments by 1 per handshake, out_word stable while stalled.
- Random in_valid gaps during LOAD -> out_valid asserts exactly one cycle after the 16th accepted word; in_valid held high during EXPAND consumes nothing.
- g_reset pulsed after 30 outputs -> out_valid=0, in_ready=1 next cycle; a following "abc" block yields the correct W16/W17.
- With SHA256_MSCHED_ABORT_EN: abort after 7 loaded words -> next 16 words form a fresh block; abort together with an out handshake -> handshake ignored, state=LOAD.
